// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and backend memory handshakes seen by the
// unified-memory arbiter. The arbiter uses the slave view; the pipeline and
// memory model together form the master view.
interface mem_port_arbiter_if;
   // Fetch side
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   // Data side
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   // Backend memory
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   // Status
   logic        err;
   logic        owner;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
             err, owner
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
             err, owner
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing a single-ported unified memory between instruction fetch and
// data access. Data side has priority; fetch is forced a grant after DM_MAX
// consecutive data grants made while it was waiting. Accesses that never see
// mem_ack complete after TIMEOUT cycles with err raised.
module mem_port_arbiter #(
   parameter int unsigned DM_MAX  = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input logic              CLOCK,
   input logic              RESET,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned SW = (DM_MAX > 0)  ? $clog2(DM_MAX + 1) : 1;
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT)    : 1;

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e          state_q, state_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [31:0]     mem_addr_q, mem_addr_d;
   logic [31:0]     mem_wdata_q, mem_wdata_d;
   logic [31:0]     if_rdata_q, if_rdata_d;
   logic [31:0]     dm_rdata_q, dm_rdata_d;
   logic            if_ready_q, if_ready_d;
   logic            dm_ready_q, dm_ready_d;
   logic            err_q, err_d;
   logic            owner_q, owner_d;

   logic            starve_full;
   logic            tmo_hit;
   logic            grant_dm;
   logic            grant_if;

   assign starve_full = (starve_q == SW'(DM_MAX));
   // Timeout fires on the last allowed ACCESS cycle; a zero TIMEOUT never fires.
   assign tmo_hit     = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 32'd1));
   assign grant_dm    = bus.dm_req && (!bus.if_req || !starve_full);
   assign grant_if    = bus.if_req && !grant_dm;

   // Next-state and output logic for the IDLE/ACCESS/RESP sequence
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      tmo_d       = '0;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_ready_d  = 1'b0;
      dm_ready_d  = 1'b0;
      err_d       = 1'b0;
      owner_d     = owner_q;

      unique case (state_q)
         StIdle: begin
            if (grant_dm) begin
               state_d     = StAccess;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.dm_we;
               mem_addr_d  = bus.dm_addr;
               mem_wdata_d = bus.dm_wdata;
               owner_d     = 1'b1;
               // Only grants that made fetch wait count toward starvation
               if (bus.if_req && !starve_full) begin
                  starve_d = starve_q + SW'(1);
               end
            end else if (grant_if) begin
               state_d    = StAccess;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = bus.if_addr;
               owner_d    = 1'b0;
               starve_d   = '0;
            end
         end

         StAccess: begin
            if (bus.mem_ack) begin
               state_d   = StResp;
               mem_req_d = 1'b0;
               if (owner_q) begin
                  dm_ready_d = 1'b1;
                  if (!mem_we_q) begin
                     dm_rdata_d = bus.mem_rdata;
                  end
               end else begin
                  if_ready_d = 1'b1;
                  if_rdata_d = bus.mem_rdata;
               end
            end else if (tmo_hit) begin
               state_d   = StResp;
               mem_req_d = 1'b0;
               err_d     = 1'b1;
               if (owner_q) begin
                  dm_ready_d = 1'b1;
                  dm_rdata_d = '0;
               end else begin
                  if_ready_d = 1'b1;
                  if_rdata_d = '0;
               end
            end else if (TIMEOUT != 0) begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         StResp: begin
            // Requests are deliberately ignored here so a still-high req is
            // not granted a second time on its own ready cycle.
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         state_q     <= StIdle;
         starve_q    <= '0;
         tmo_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_ready_q  <= 1'b0;
         dm_ready_q  <= 1'b0;
         err_q       <= 1'b0;
         owner_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         tmo_q       <= tmo_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_ready_q  <= if_ready_d;
         dm_ready_q  <= dm_ready_d;
         err_q       <= err_d;
         owner_q     <= owner_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.if_ready  = if_ready_q;
   assign bus.dm_ready  = dm_ready_q;
   assign bus.err       = err_q;
   assign bus.owner     = owner_q;

endmodule
